// File: rtl/fifo_status_pkg.sv
// fifo_status_pkg: shared state, request-kind and timeout definitions for the
// FIFO status arbiter family.
package fifo_status_pkg;
    typedef enum logic [2:0] {IDLE, REQ, WAIT_DONE, FSH, TIME_ERR, RESET_CHAIN} state_t;
    typedef logic kind_t;
    localparam kind_t KIND_BURST = 1'b0;
    localparam kind_t KIND_TAIL = 1'b1;
    localparam int unsigned DEF_TIMEOUT = 32'h00FFF000;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant over a request vector; the pointer
// moves to the slot after the winner whenever a grant is taken.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          clr,
    input  logic          advance,
    input  logic [N-1:0]  request,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] gidx
);
    logic [PW-1:0] ptr;

    // scan from the highest distance down so the closest requester to ptr wins
    always_comb begin
        grant = '0;
        gidx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (request[(int'(ptr) + i) % N]) begin
                grant = '0;
                grant[(int'(ptr) + i) % N] = 1'b1;
                gidx = PW'((int'(ptr) + i) % N);
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (clr)
            ptr <= '0;
        else if (advance && |request)
            ptr <= (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
    end
endmodule

// File: rtl/fifo_status_arb.sv
// fifo_status_arb: round-robin burst/tail request scheduler for CH write-side
// FIFOs sharing one AXI write master, with timeout and per-channel chain reset.
module fifo_status_arb
    import fifo_status_pkg::*;
#(
    parameter int CH = 4,
    parameter int CWIDTH = 10,
    parameter int LSIZE = 9,
    parameter int THRESHOLD = 200,
    parameter int BURST_LEN = 100,
    parameter int TO_W = 24,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                enable,
    input  logic                f_rst_status,
    input  logic [CH*CWIDTH-1:0] count,
    input  logic [CH-1:0]       fifo_empty,
    input  logic [CH-1:0]       tail_pend,
    input  logic [CH*LSIZE-1:0] tail_len,
    output logic                req,
    output logic                req_tail,
    output logic [CHW-1:0]      req_ch,
    output logic [LSIZE-1:0]    req_len,
    input  logic                resp,
    input  logic                done,
    output logic [CH-1:0]       burst_done,
    output logic [CH-1:0]       tail_done,
    output logic [CH-1:0]       rst_chain,
    output logic                busy,
    output logic                timeout_err
);
    logic [CH-1:0] tail_el, burst_el, el, grant;
    logic [CHW-1:0] gidx;
    logic [CH-1:0] own;
    logic [TO_W-1:0] tcnt;
    logic tmo, start, gkind;
    state_t state;
    kind_t kind;

    for (genvar i = 0; i < CH; i++) begin : g_el
        assign tail_el[i] = tail_pend[i] & ~fifo_empty[i] & (count[i*CWIDTH +: CWIDTH] != '0)
                          & (tail_len[i*LSIZE +: LSIZE] != '0);
        assign burst_el[i] = (count[i*CWIDTH +: CWIDTH] >= CWIDTH'(THRESHOLD)) & ~fifo_empty[i] & ~tail_pend[i];
    end
    assign el = tail_el | burst_el;
    assign start = (state == IDLE) && enable && (|el);
    assign gkind = |(grant & tail_el);
    assign own = CH'(1) << req_ch;
    assign tmo = (tcnt == TO_W'(TIMEOUT - 1));

    rr_arbiter #(.N(CH)) u_arb (
        .clock(clock), .rst(rst), .clr(f_rst_status), .advance(start),
        .request(el), .grant(grant), .gidx(gidx)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= IDLE; kind <= KIND_BURST; tcnt <= '0;
            req <= 1'b0; req_tail <= 1'b0; req_ch <= '0; req_len <= '0;
            burst_done <= '0; tail_done <= '0; rst_chain <= '0;
            busy <= 1'b0; timeout_err <= 1'b0;
        end else if (f_rst_status) begin
            state <= IDLE; kind <= KIND_BURST; tcnt <= '0;
            req <= 1'b0; req_tail <= 1'b0; req_ch <= '0; req_len <= '0;
            burst_done <= '0; tail_done <= '0; rst_chain <= '0;
            busy <= 1'b0; timeout_err <= 1'b0;
        end else begin
            burst_done <= '0;
            tail_done <= '0;
            rst_chain <= '0;
            tcnt <= (state == REQ || state == WAIT_DONE) ? tcnt + 1'b1 : '0;
            case (state)
                IDLE: if (start) begin
                    state <= REQ;
                    busy <= 1'b1;
                    kind <= gkind;
                    req_ch <= gidx;
                    req_len <= gkind ? tail_len[int'(gidx)*LSIZE +: LSIZE] : LSIZE'(BURST_LEN);
                    req <= ~gkind;
                    req_tail <= gkind;
                end
                REQ: if (resp) begin
                    req <= 1'b0;
                    req_tail <= 1'b0;
                    state <= done ? FSH : WAIT_DONE;
                    if (done && kind == KIND_TAIL) tail_done <= own;
                    if (done && kind == KIND_BURST) burst_done <= own;
                end else if (tmo) begin
                    req <= 1'b0;
                    req_tail <= 1'b0;
                    state <= TIME_ERR;
                    rst_chain <= own;
                    timeout_err <= 1'b1;
                end
                WAIT_DONE: if (done) begin
                    state <= FSH;
                    if (kind == KIND_TAIL) tail_done <= own;
                    else burst_done <= own;
                end else if (tmo) begin
                    state <= TIME_ERR;
                    rst_chain <= own;
                    timeout_err <= 1'b1;
                end
                FSH: begin
                    state <= IDLE;
                    busy <= 1'b0;
                end
                TIME_ERR: state <= RESET_CHAIN;
                RESET_CHAIN: if (fifo_empty[req_ch]) begin
                    state <= IDLE;
                    busy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_status_arb.sv
// tb_fifo_status_arb: directed checks of grant order, burst/tail requests,
// timeout chain reset, synchronous abort and enable gating.
module tb_fifo_status_arb;
    logic clock = 1'b0;
    logic rst, enable, f_rst_status, resp, done;
    logic [39:0] count;
    logic [3:0] fifo_empty, tail_pend;
    logic [35:0] tail_len;
    logic req, req_tail, busy, timeout_err;
    logic [1:0] req_ch;
    logic [8:0] req_len;
    logic [3:0] burst_done, tail_done, rst_chain;
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    fifo_status_arb #(.TIMEOUT(16)) dut (
        .clock(clock), .rst(rst), .enable(enable), .f_rst_status(f_rst_status),
        .count(count), .fifo_empty(fifo_empty), .tail_pend(tail_pend), .tail_len(tail_len),
        .req(req), .req_tail(req_tail), .req_ch(req_ch), .req_len(req_len),
        .resp(resp), .done(done), .burst_done(burst_done), .tail_done(tail_done),
        .rst_chain(rst_chain), .busy(busy), .timeout_err(timeout_err)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int c, input logic [9:0] cnt, input logic emp);
        count[c*10 +: 10] = cnt;
        fifo_empty[c] = emp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; enable = 1'b1; f_rst_status = 1'b0; resp = 1'b0; done = 1'b0;
        count = '0; fifo_empty = 4'hF; tail_pend = '0; tail_len = '0;
        #12;
        chk("reset_flags", 32'({req, req_tail, busy, timeout_err, burst_done, tail_done, rst_chain}), 32'd0);
        chk("reset_ch_len", 32'({req_ch, req_len}), 32'd0);
        tick(); rst = 1'b0;
        tick();
        chk("idle_no_req", 32'({req, busy}), 32'd0);

        // single burst on channel 2 with slow master
        set_ch(2, 10'd200, 1'b0);
        tick();
        chk("b_req", 32'({req, req_tail, busy}), 32'b101);
        chk("b_ch", 32'(req_ch), 32'd2);
        chk("b_len", 32'(req_len), 32'd100);
        set_ch(2, 10'd0, 1'b1);
        tick(2); resp = 1'b1;
        tick(); resp = 1'b0;
        chk("b_req_drop", 32'({req, busy}), 32'b01);
        tick(9); done = 1'b1;
        chk("b_no_early_done", 32'(burst_done), 32'd0);
        tick(); done = 1'b0;
        chk("b_done", 32'(burst_done), 32'b0100);
        tick();
        chk("b_done_once", 32'(burst_done), 32'd0);
        chk("b_idle", 32'(busy), 32'd0);
        chk("b_hold", 32'({req_ch, req_len}), 32'({2'd2, 9'd100}));

        // round-robin with always-ready master, ptr restarted by rst
        rst = 1'b1; tick(); rst = 1'b0;
        set_ch(0, 10'd250, 1'b0); set_ch(1, 10'd250, 1'b0); set_ch(3, 10'd250, 1'b0);
        resp = 1'b1; done = 1'b1;
        tick();
        chk("rr_g0", 32'({req, req_ch}), 32'({1'b1, 2'd0}));
        tick();
        chk("rr_done0", 32'({req, burst_done}), 32'({1'b0, 4'b0001}));
        tick();
        chk("rr_idle_gap", 32'({req, busy, burst_done}), 32'd0);
        tick();
        chk("rr_g1", 32'({req, req_ch}), 32'({1'b1, 2'd1}));
        tick(3);
        chk("rr_g3", 32'({req, req_ch}), 32'({1'b1, 2'd3}));
        tick(3);
        chk("rr_g0_wrap", 32'({req, req_ch}), 32'({1'b1, 2'd0}));
        set_ch(0, 10'd0, 1'b1); set_ch(1, 10'd0, 1'b1); set_ch(3, 10'd0, 1'b1);
        tick(2); resp = 1'b0; done = 1'b0;

        // tail on channel 1 beats its burst eligibility
        set_ch(1, 10'd300, 1'b0); tail_pend[1] = 1'b1; tail_len[9 +: 9] = 9'd37;
        tick();
        chk("t_req", 32'({req, req_tail}), 32'b01);
        chk("t_ch_len", 32'({req_ch, req_len}), 32'({2'd1, 9'd37}));
        resp = 1'b1; done = 1'b1;
        tick();
        chk("t_done", 32'({tail_done, burst_done}), 32'({4'b0010, 4'b0000}));
        resp = 1'b0; done = 1'b0; tail_pend[1] = 1'b0; set_ch(1, 10'd0, 1'b1);
        tick();
        chk("t_done_once", 32'({tail_done, busy}), 32'd0);

        // timeout on channel 3 with no response
        set_ch(3, 10'd200, 1'b0);
        tick();
        chk("to_req", 32'({req, req_ch}), 32'({1'b1, 2'd3}));
        tick(15);
        chk("to_cycle16", 32'({req, rst_chain, timeout_err}), 32'({1'b1, 4'b0000, 1'b0}));
        tick();
        chk("to_fire", 32'({req, rst_chain, timeout_err}), 32'({1'b0, 4'b1000, 1'b1}));
        tick(3);
        chk("to_hold_chain", 32'({busy, rst_chain}), 32'({1'b1, 4'b0000}));
        set_ch(3, 10'd0, 1'b1);
        tick();
        chk("to_back_idle", 32'({busy, timeout_err}), 32'b01);

        // synchronous abort in WAIT_DONE on channel 2
        set_ch(2, 10'd200, 1'b0);
        tick();
        chk("fr_req", 32'({req, req_ch}), 32'({1'b1, 2'd2}));
        set_ch(2, 10'd0, 1'b1); resp = 1'b1;
        tick(); resp = 1'b0;
        f_rst_status = 1'b1;
        tick(); f_rst_status = 1'b0; done = 1'b1;
        chk("fr_clear", 32'({req, req_tail, busy, timeout_err, req_ch, req_len}), 32'd0);
        tick(); done = 1'b0;
        chk("fr_no_done", 32'({burst_done, tail_done}), 32'd0);
        tick();
        chk("fr_no_done2", 32'({burst_done, tail_done, busy}), 32'd0);

        // enable gating
        enable = 1'b0; set_ch(1, 10'd250, 1'b0);
        tick(3);
        chk("en_blocked", 32'({req, busy}), 32'd0);
        enable = 1'b1;
        tick();
        chk("en_req", 32'({req, req_ch}), 32'({1'b1, 2'd1}));
        set_ch(1, 10'd0, 1'b1); resp = 1'b1; done = 1'b1;
        tick();
        chk("en_done", 32'(burst_done), 32'b0010);
        resp = 1'b0; done = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
